lavatory_monitor: RTL
=====================

LAVATORY_MONITOR -- requirements
Module: lavatory_monitor

Interface
REQ-001 Parameter NLAV, default 3: number of lavatories, range 1..16.
REQ-002 Parameter FEMALE_MASK [NLAV-1:0], default 'b001: bit i = 1 marks lavatory i as women-only.
REQ-003 Parameter DEB_CYC, default 4: consecutive stable cycles needed to accept a lock change, range 1..255.
REQ-004 Parameter OCC_LIMIT, default 200: occupied cycles before overtime is flagged, range 1..65535.
REQ-005 clk_2  input  1  single clock; all state SHALL change on its rising edge only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 lock  input  NLAV  raw door sensors (1 = locked); asynchronous to clk_2 and may bounce.
REQ-008 occupied  output  NLAV  debounced lock state per lavatory.
REQ-009 overtime  output  NLAV  lavatory i has been occupied for at least OCC_LIMIT cycles.
REQ-010 led_female  output  1  at least one lavatory is free; every lavatory is usable by women.
REQ-011 led_male  output  1  at least one lavatory with FEMALE_MASK bit = 0 is free.
REQ-012 free_count  output  $clog2(NLAV+1)  number of free lavatories.
REQ-013 overtime_pulse  output  1  one-cycle pulse when any overtime bit rises.

Function
REQ-014 Each lock bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-015 Each channel SHALL implement the FSM FREE -> LOCKING -> OCCUPIED -> UNLOCKING -> FREE.
REQ-016 FREE -> LOCKING when synced = 1; the debounce counter loads 1.
REQ-017 In LOCKING, synced = 1 increments the counter; reaching DEB_CYC goes to OCCUPIED; synced = 0 returns to FREE and clears the counter.
REQ-018 OCCUPIED <-> UNLOCKING SHALL be symmetric with synced = 0; a bounce in UNLOCKING returns to OCCUPIED and keeps the occupancy count.
REQ-019 occupied[i] SHALL be 1 in OCCUPIED and UNLOCKING, and 0 in FREE and LOCKING.
REQ-020 Latency: a clean lock edge SHALL reach occupied after 2 + DEB_CYC cycles; led_*, free_count and overtime_pulse are registered one further cycle.
REQ-021 The occupancy counter SHALL increment every cycle while occupied[i] = 1, saturate at OCC_LIMIT and clear on entry to FREE.
REQ-022 overtime[i] SHALL equal (occupancy counter == OCC_LIMIT) and SHALL clear in the same cycle the channel enters FREE.
REQ-023 overtime_pulse SHALL assert for exactly one cycle per rising overtime bit; simultaneous rises produce a single pulse.
REQ-024 free_count SHALL be the popcount of ~occupied; the value NLAV SHALL be representable without wrap.
REQ-025 If all lavatories are women-only, led_male SHALL be constant 0.

Reset
REQ-026 While reset = 1, on each clk_2 edge: synchronisers 0, all FSMs FREE, all counters 0, occupied 0, overtime 0, overtime_pulse 0.
REQ-027 After reset, led_female = 1, led_male = (FEMALE_MASK != all-ones) and free_count = NLAV.
REQ-028 Reset asserted mid-debounce or mid-occupancy SHALL abandon that operation with no residual pulse after release.

Structure
REQ-029 Package lav_pkg SHALL hold the channel state enum (FREE, LOCKING, OCCUPIED, UNLOCKING) and the default parameter constants.
REQ-030 Sub-module lav_channel SHALL contain the synchroniser, debounce FSM, occupancy counter and overtime flag; the top instantiates NLAV channels and the registered aggregation.

Verification
REQ-031 Defaults, after reset: lock = 000 for 10 cycles -> occupied = 000, led_female = 1, led_male = 1, free_count = 3.
REQ-032 lock[0] 0 -> 1 clean -> occupied[0] rises 6 cycles later and led_male stays 1; then lock[1] and lock[2] set -> led_female = 0, led_male = 0, free_count = 0.
REQ-033 Bounce: lock[1] toggles 1,0,1,0 with 1-cycle periods, then holds 0 -> occupied[1] never asserts.
REQ-034 OCC_LIMIT = 8: lock[2] held -> overtime[2] rises 8 cycles after occupied[2] with a single overtime_pulse; unlock -> overtime[2] clears on entry to FREE.
REQ-035 Reset pulsed 2 cycles into LOCKING with lock[0] still 1 -> FSM is FREE after reset, then occupied[0] follows 6 cycles after reset release.
REQ-036 NLAV = 5, FEMALE_MASK = 'b11111, all unlocked -> led_male = 0 constantly and free_count = 5.

Source files
------------

// File: rtl/lav_pkg.sv
// Shared types and default constants for the lavatory occupancy monitor.
package lav_pkg;

    // Per-lavatory debounce state
    typedef enum logic [1:0] {
        LAV_FREE      = 2'd0,
        LAV_LOCKING   = 2'd1,
        LAV_OCCUPIED  = 2'd2,
        LAV_UNLOCKING = 2'd3
    } lav_state_e;

    localparam int unsigned LAV_NLAV_DEF        = 3;
    localparam logic [15:0] LAV_FEMALE_MASK_DEF = 16'b0000_0000_0000_0001;
    localparam int unsigned LAV_DEB_CYC_DEF     = 4;
    localparam int unsigned LAV_OCC_LIMIT_DEF   = 200;

    // Counter widths cover the full legal parameter ranges
    localparam int unsigned LAV_DEB_W = 8;
    localparam int unsigned LAV_OCC_W = 16;

endpackage

// File: rtl/lav_channel.sv
// One lavatory: lock synchroniser, debounce FSM, occupancy timer and overtime flag.
module lav_channel
    import lav_pkg::*;
#(
    parameter int unsigned DEB_CYC   = LAV_DEB_CYC_DEF,
    parameter int unsigned OCC_LIMIT = LAV_OCC_LIMIT_DEF
) (
    input  logic clk_2,
    input  logic reset,
    input  logic lock_i,
    output logic occupied_o,
    output logic overtime_o
);

    localparam logic [LAV_DEB_W-1:0] DEB_LAST = LAV_DEB_W'(DEB_CYC - 1);
    localparam logic [LAV_OCC_W-1:0] OCC_MAX  = LAV_OCC_W'(OCC_LIMIT);
    // With a one-cycle debounce the first stable sample already commits the change
    localparam bit DEB_ONE = (DEB_CYC == 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    lav_state_e           state_q, state_d;
    logic [LAV_DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [LAV_OCC_W-1:0] occ_cnt_q, occ_cnt_d;
    logic                 occupied_q, occupied_d;
    logic                 overtime_q, overtime_d;
    logic                 synced;

    assign synced     = sync2_q;
    assign occupied_o = occupied_q;
    assign overtime_o = overtime_q;

    // Next-state: synchroniser shift, debounce FSM, occupancy timer
    always_comb begin
        sync1_d   = lock_i;
        sync2_d   = sync1_q;
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        occ_cnt_d = occ_cnt_q;

        case (state_q)
            LAV_FREE: begin
                if (synced) begin
                    if (DEB_ONE) begin
                        state_d   = LAV_OCCUPIED;
                        deb_cnt_d = '0;
                    end else begin
                        state_d   = LAV_LOCKING;
                        deb_cnt_d = LAV_DEB_W'(1);
                    end
                end
            end
            LAV_LOCKING: begin
                if (!synced) begin
                    state_d   = LAV_FREE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = LAV_OCCUPIED;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + LAV_DEB_W'(1);
                end
            end
            LAV_OCCUPIED: begin
                if (!synced) begin
                    if (DEB_ONE) begin
                        state_d   = LAV_FREE;
                        deb_cnt_d = '0;
                    end else begin
                        state_d   = LAV_UNLOCKING;
                        deb_cnt_d = LAV_DEB_W'(1);
                    end
                end
            end
            LAV_UNLOCKING: begin
                if (synced) begin
                    state_d   = LAV_OCCUPIED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = LAV_FREE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + LAV_DEB_W'(1);
                end
            end
            default: begin
                state_d   = LAV_FREE;
                deb_cnt_d = '0;
            end
        endcase

        // Timer runs while occupied, saturates, and is cleared as the channel frees up
        if (state_d == LAV_FREE) begin
            occ_cnt_d = '0;
        end else if (occupied_q && (occ_cnt_q != OCC_MAX)) begin
            occ_cnt_d = occ_cnt_q + LAV_OCC_W'(1);
        end

        occupied_d = (state_d == LAV_OCCUPIED) || (state_d == LAV_UNLOCKING);
        overtime_d = (occ_cnt_d == OCC_MAX);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_2) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= LAV_FREE;
            deb_cnt_q  <= '0;
            occ_cnt_q  <= '0;
            occupied_q <= 1'b0;
            overtime_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            occ_cnt_q  <= occ_cnt_d;
            occupied_q <= occupied_d;
            overtime_q <= overtime_d;
        end
    end

endmodule

// File: rtl/lavatory_monitor.sv
// Cabin lavatory monitor: NLAV debounced channels plus registered status LEDs and counts.
module lavatory_monitor
    import lav_pkg::*;
#(
    parameter int unsigned       NLAV        = LAV_NLAV_DEF,
    parameter logic [NLAV-1:0]   FEMALE_MASK = LAV_FEMALE_MASK_DEF[NLAV-1:0],
    parameter int unsigned       DEB_CYC     = LAV_DEB_CYC_DEF,
    parameter int unsigned       OCC_LIMIT   = LAV_OCC_LIMIT_DEF
) (
    input  logic                        clk_2,
    input  logic                        reset,
    input  logic [NLAV-1:0]             lock,
    output logic [NLAV-1:0]             occupied,
    output logic [NLAV-1:0]             overtime,
    output logic                        led_female,
    output logic                        led_male,
    output logic [$clog2(NLAV+1)-1:0]   free_count,
    output logic                        overtime_pulse
);

    localparam int unsigned CNT_W = $clog2(NLAV + 1);
    // Men's LED can only ever light if some lavatory is not women-only
    localparam logic LED_MALE_RST = (FEMALE_MASK != {NLAV{1'b1}});

    logic             led_female_q, led_female_d;
    logic             led_male_q, led_male_d;
    logic [CNT_W-1:0] free_count_q, free_count_d;
    logic             overtime_pulse_q, overtime_pulse_d;
    logic [NLAV-1:0]  overtime_prev_q, overtime_prev_d;

    for (genvar i = 0; i < NLAV; i++) begin : g_ch
        lav_channel #(
            .DEB_CYC   (DEB_CYC),
            .OCC_LIMIT (OCC_LIMIT)
        ) u_ch (
            .clk_2      (clk_2),
            .reset      (reset),
            .lock_i     (lock[i]),
            .occupied_o (occupied[i]),
            .overtime_o (overtime[i])
        );
    end

    // Aggregate free count, LED requests and overtime edge detection
    always_comb begin
        free_count_d     = '0;
        led_male_d       = 1'b0;
        for (int i = 0; i < NLAV; i++) begin
            if (!occupied[i]) begin
                free_count_d = free_count_d + CNT_W'(1);
                if (!FEMALE_MASK[i]) begin
                    led_male_d = 1'b1;
                end
            end
        end
        led_female_d     = (free_count_d != '0);
        overtime_pulse_d = |(overtime & ~overtime_prev_q);
        overtime_prev_d  = overtime;
    end

    // Output registers with synchronous reset to the all-free picture
    always_ff @(posedge clk_2) begin
        if (reset) begin
            led_female_q     <= 1'b1;
            led_male_q       <= LED_MALE_RST;
            free_count_q     <= CNT_W'(NLAV);
            overtime_pulse_q <= 1'b0;
            overtime_prev_q  <= '0;
        end else begin
            led_female_q     <= led_female_d;
            led_male_q       <= led_male_d;
            free_count_q     <= free_count_d;
            overtime_pulse_q <= overtime_pulse_d;
            overtime_prev_q  <= overtime_prev_d;
        end
    end

    assign led_female     = led_female_q;
    assign led_male       = led_male_q;
    assign free_count     = free_count_q;
    assign overtime_pulse = overtime_pulse_q;

endmodule
